// File: rtl/serv_shift_xlen_if.sv
// Serial operand/result bundle for serv_shift_xlen.
// The master drives the operand side; the slave (the shifter) drives results.
interface serv_shift_xlen_if #(
    parameter int XLEN = 32,
    parameter int SW   = $clog2(XLEN)
);
    logic          i_start;
    logic [2:0]    i_op;
    logic          i_word;
    logic [SW-1:0] i_shamt;
    logic          i_d;
    logic          o_busy;
    logic          o_q_valid;
    logic          o_q;
    logic          o_done;

    modport master (
        output i_start, i_op, i_word, i_shamt, i_d,
        input  o_busy, o_q_valid, o_q, o_done
    );

    modport slave (
        input  i_start, i_op, i_word, i_shamt, i_d,
        output o_busy, o_q_valid, o_q, o_done
    );
endinterface

// File: rtl/serv_shift_xlen.sv
// Serial shift/rotate unit: loads an XLEN-bit operand LSB first, then replays
// the shifted/rotated result LSB first. Supports RV64 *W ops when XLEN=64.
//
// state  | meaning
// IDLE   | waiting for i_start; first operand bit captured with the start
// LOAD   | capturing operand bits 1..XLEN-1
// OUT    | emitting result bit cnt; o_done on the last bit
module serv_shift_xlen #(
    parameter int XLEN = 32,
    parameter int SW   = $clog2(XLEN)
) (
    input logic              i_clk,
    input logic              i_rst,
    serv_shift_xlen_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_OUT} state_t;

    localparam logic [SW-1:0] LAST      = SW'(XLEN - 1);
    localparam logic [SW:0]   WIDE_XLEN = (SW+1)'(XLEN);

    state_t         r_state;
    logic [SW-1:0]  r_cnt;
    logic [XLEN-1:0] r_buf;
    logic [2:0]     r_op;
    logic           r_word;
    logic [SW-1:0]  r_shamt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_op     <= bus.i_op;
                        r_word   <= bus.i_word;
                        r_shamt  <= bus.i_shamt;
                        r_buf[0] <= bus.i_d;
                        r_cnt    <= SW'(1);
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_buf[r_cnt] <= bus.i_d;
                    r_cnt        <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= S_OUT;
                end
                S_OUT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Word mode narrows the operation to 32 bits; bits above 31 repeat bit 31.
    logic            w_word;
    logic [SW-1:0]   w_s;
    logic [SW-1:0]   w_k;
    logic [SW-1:0]   w_mask;
    logic [SW:0]     w_width;
    logic [SW:0]     w_sum;
    logic [SW-1:0]   w_diff;
    logic            w_bit;

    assign w_word  = (XLEN == 64) && r_word;
    assign w_s     = w_word ? SW'(r_shamt[4:0]) : r_shamt;
    assign w_k     = (w_word && (r_cnt > SW'(31))) ? SW'(31) : r_cnt;
    assign w_mask  = w_word ? SW'(31) : LAST;
    assign w_width = w_word ? (SW+1)'(32) : WIDE_XLEN;
    assign w_sum   = {1'b0, w_k} + {1'b0, w_s};
    assign w_diff  = w_k - w_s;

    always_comb begin
        w_bit = 1'b0;
        case (r_op)
            3'b000: if (w_k >= w_s) w_bit = r_buf[w_diff];
            3'b001: if (w_sum < w_width) w_bit = r_buf[w_sum[SW-1:0]];
            3'b010: w_bit = (w_sum < w_width) ? r_buf[w_sum[SW-1:0]] : r_buf[w_mask];
            3'b011: w_bit = r_buf[w_diff & w_mask];
            3'b100: w_bit = r_buf[w_sum[SW-1:0] & w_mask];
            default: w_bit = 1'b0;
        endcase
    end

    assign bus.o_busy    = (r_state != S_IDLE);
    assign bus.o_q_valid = (r_state == S_OUT);
    assign bus.o_q       = (r_state == S_OUT) && w_bit;
    assign bus.o_done    = (r_state == S_OUT) && (r_cnt == LAST);
endmodule

// File: tb/tb_serv_shift_xlen.sv
// Self-checking bench for serv_shift_xlen: directed vectors plus random ops
// against an arithmetic reference model, on XLEN=32 and XLEN=64 instances.
module tb_serv_shift_xlen;
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 i_clk = ~i_clk;

    serv_shift_xlen_if #(.XLEN(32)) if32 ();
    serv_shift_xlen_if #(.XLEN(64)) if64 ();

    serv_shift_xlen #(.XLEN(32)) dut32 (.i_clk(i_clk), .i_rst(i_rst), .bus(if32.slave));
    serv_shift_xlen #(.XLEN(64)) dut64 (.i_clk(i_clk), .i_rst(i_rst), .bus(if64.slave));

    function automatic logic [63:0] ref_model(input int xl, input logic [2:0] op,
                                              input bit word, input int shamt,
                                              input logic [63:0] d);
        int w;
        int s;
        logic [63:0] m;
        logic [63:0] x;
        logic [63:0] r;
        if (xl == 64 && word) begin
            w = 32;
            s = shamt % 32;
        end else begin
            w = xl;
            s = shamt % xl;
        end
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = d & m;
        case (op)
            3'd0:    r = (x << s) & m;
            3'd1:    r = x >> s;
            3'd2:    r = (x >> s) | (x[w-1] ? (~(m >> s) & m) : 64'd0);
            3'd3:    r = ((x << s) | (x >> (w - s))) & m;
            3'd4:    r = ((x >> s) | (x << (w - s))) & m;
            default: r = 64'd0;
        endcase
        if (xl == 64 && word) r = {{32{r[31]}}, r[31:0]};
        return r;
    endfunction

    task automatic drive(input bit is64, input logic st, input logic [2:0] op,
                         input logic w, input logic [5:0] sh, input logic dd);
        if (is64) begin
            if64.i_start = st;  if64.i_op = op; if64.i_word = w;
            if64.i_shamt = sh;  if64.i_d  = dd;
            if32.i_start = 1'b0;
        end else begin
            if32.i_start = st;  if32.i_op = op; if32.i_word = w;
            if32.i_shamt = sh[4:0]; if32.i_d = dd;
            if64.i_start = 1'b0;
        end
    endtask

    function automatic logic [3:0] outs(input bit is64);
        return is64 ? {if64.o_busy, if64.o_q_valid, if64.o_q, if64.o_done}
                    : {if32.o_busy, if32.o_q_valid, if32.o_q, if32.o_done};
    endfunction

    task automatic run_op(input bit is64, input logic [2:0] op, input bit word,
                          input logic [5:0] shamt, input logic [63:0] d,
                          input logic [63:0] exp, input string tag);
        int          xl;
        logic [63:0] got;
        logic [63:0] want;
        logic [3:0]  o;
        int          bad;
        xl   = is64 ? 64 : 32;
        got  = '0;
        bad  = -1;
        want = is64 ? exp : {32'd0, exp[31:0]};
        @(negedge i_clk);
        checks++;
        assert (outs(is64) === 4'b0000)
        else begin
            errors++;
            $error("FAIL %s idle: outs=%b expected 0000", tag, outs(is64));
        end
        drive(is64, 1'b1, op, word, shamt, d[0]);
        for (int c = 1; c < 2 * xl; c++) begin
            @(negedge i_clk);
            o = outs(is64);
            if (c < xl) begin
                if (o !== 4'b1000 && bad < 0) bad = c;
            end else begin
                got[c-xl] = o[1];
                if ((o[3] !== 1'b1 || o[2] !== 1'b1 || o[0] !== (c == 2 * xl - 1)) && bad < 0)
                    bad = c;
            end
            // Random i_start pulses and input churn while busy must be ignored.
            drive(is64, (c == 2 * xl - 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                  3'($urandom), 1'($urandom), 6'($urandom),
                  (c < xl) ? d[c] : 1'($urandom));
        end
        @(posedge i_clk);
        #1;
        drive(is64, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("FAIL %s result: got=%h expected %h", tag, got, want);
        end
        checks++;
        assert (bad === -1)
        else begin
            errors++;
            $error("FAIL %s timing: first bad cycle=%0d expected -1", tag, bad);
        end
    endtask

    initial begin
        logic [63:0] d;
        logic [2:0]  op;
        logic [5:0]  sh;
        bit          w;

        drive(1'b0, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 1'b0, 6'd0, 1'b0);
        repeat (3) @(negedge i_clk);
        checks++;
        assert (outs(1'b0) === 4'b0000)
        else begin errors++; $error("FAIL reset32: outs=%b expected 0000", outs(1'b0)); end
        checks++;
        assert (outs(1'b1) === 4'b0000)
        else begin errors++; $error("FAIL reset64: outs=%b expected 0000", outs(1'b1)); end
        i_rst = 1'b0;

        run_op(0, 3'd2, 0, 6'd4,  64'h80000010, 64'hF8000001, "sra32");
        run_op(0, 3'd4, 0, 6'd1,  64'h00000001, 64'h80000000, "ror1");
        run_op(0, 3'd3, 0, 6'd1,  64'h80000000, 64'h00000001, "rol1");
        run_op(0, 3'd4, 0, 6'd8,  64'h12345678, 64'h78123456, "ror8");
        run_op(0, 3'd0, 0, 6'd31, 64'h00000003, 64'h80000000, "sll31");
        run_op(0, 3'd1, 0, 6'd31, 64'hFFFFFFFF, 64'h00000001, "srl31");
        run_op(0, 3'd7, 0, 6'd4,  64'hFFFFFFFF, 64'h00000000, "rsvd7");
        for (int i = 0; i < 5; i++) begin
            d = {32'd0, $urandom};
            run_op(0, 3'(i), 0, 6'd0, d, d, "ident32");
        end
        run_op(1, 3'd0, 1, 6'd1,  64'h0000000040000000, 64'hFFFFFFFF80000000, "sllw");
        run_op(1, 3'd2, 1, 6'd37, 64'h0000000080000000, 64'hFFFFFFFFFC000000, "sraw");
        run_op(1, 3'd1, 0, 6'd63, 64'h8000000000000000, 64'h0000000000000001, "srl63");

        // Reset in the middle of an output phase, then a clean operation.
        @(negedge i_clk);
        d = 64'h80000010;
        drive(0, 1'b1, 3'd2, 1'b0, 6'd4, d[0]);
        for (int c = 1; c <= 40; c++) begin
            @(negedge i_clk);
            if (c == 40) i_rst = 1'b1;
            drive(0, 1'b0, 3'd0, 1'b0, 6'd0, (c < 32) ? d[c] : 1'b0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        checks++;
        assert (outs(1'b0) === 4'b0000)
        else begin errors++; $error("FAIL midrst: outs=%b expected 0000", outs(1'b0)); end
        run_op(0, 3'd2, 0, 6'd4, 64'h80000010, 64'hF8000001, "after_rst");

        for (int i = 0; i < 24; i++) begin
            d  = {$urandom, $urandom};
            op = 3'($urandom_range(0, 7));
            sh = 6'($urandom);
            w  = 1'($urandom);
            run_op(0, op, w, sh, d, ref_model(32, op, w, int'(sh[4:0]), d), "rand32");
            run_op(1, op, w, sh, d, ref_model(64, op, w, int'(sh), d), "rand64");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
